// File: rtl/i2c_slave_regfile.sv
// I2C target exposing a 256 x 8 register space through one-cycle strobes.
// SCL/SDA are oversampled on the system clock, so there is no SCL-domain logic.
// Optional SCL-low bus timeout: define I2C_SLV_TIMEOUT_EN.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | bus free or not addressed, SDA released
// DEV_ADDR   | shifting device address + R/W bit
// ACK_ADDR   | driving ACK for the device address
// WORD_ADDR  | shifting the register pointer
// ACK_WORD   | driving ACK for the register pointer
// WRITE_DATA | shifting a write data byte
// ACK_DATA   | driving ACK for a write byte, write strobe when it ends
// READ_DATA  | driving a read byte, MSB first
// WAIT_MACK  | SDA released, sampling the master ACK/NACK
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         FILTER_LEN  = 4,
    parameter int         TIMEOUT_CYC = 2_500_000
) (
    input  logic       main_100mhz_clk_i,
    input  logic       fpga_rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    output logic       reg_rd_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o,
    output logic       timeout_o
);

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, ACK_ADDR, WORD_ADDR, ACK_WORD,
        WRITE_DATA, ACK_DATA, READ_DATA, WAIT_MACK
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  sync1, sync2, filt, filt_q;   // bit 0 = SCL, bit 1 = SDA
    logic [3:0]  fcnt [2];
    logic        scl_f, scl_rise, scl_fall, sda_rise, sda_fall;
    logic        bus_start, bus_stop, to_hit;
    logic [7:0]  shift;
    logic [3:0]  bit_cnt;
    logic        scl_fall_d, rd_d, mack_nack;
    logic        byte_done;

    // two-flop synchronizers followed by a stability filter per line
    always_ff @(posedge main_100mhz_clk_i) begin
        if (fpga_rst_i) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            filt   <= 2'b11;
            filt_q <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            sync1  <= {sda_i, scl_i};
            sync2  <= sync1;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == 4'(FILTER_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 4'd1;
                end
            end
        end
    end

    assign scl_f     = filt[0];
    assign scl_rise  = filt[0] & ~filt_q[0];
    assign scl_fall  = ~filt[0] & filt_q[0];
    assign sda_rise  = filt[1] & ~filt_q[1];
    assign sda_fall  = ~filt[1] & filt_q[1];
    assign bus_start = sda_fall & scl_f;
    assign bus_stop  = sda_rise & scl_f;
    assign byte_done = (bit_cnt == 4'd8);
    assign busy_o    = (state != IDLE) && (state != DEV_ADDR);

`ifdef I2C_SLV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;
    logic          to_q;

    assign to_hit    = (state != IDLE) && !scl_f && (to_cnt == '0);
    assign timeout_o = to_q;

    // down-counter of consecutive SCL-low cycles while addressed
    always_ff @(posedge main_100mhz_clk_i) begin
        if (fpga_rst_i) begin
            to_cnt <= TW'(TIMEOUT_CYC - 1);
            to_q   <= 1'b0;
        end else begin
            to_q <= to_hit;
            if ((state == IDLE) || scl_f || to_hit) to_cnt <= TW'(TIMEOUT_CYC - 1);
            else                                    to_cnt <= to_cnt - 1'b1;
        end
    end
`else
    assign to_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // state register
    always_ff @(posedge main_100mhz_clk_i) begin
        if (fpga_rst_i) state <= IDLE;
        else            state <= state_nx;
    end

    // next state: bus conditions first, then byte/ACK progress on scl_fall
    always_comb begin
        state_nx = state;
        if (bus_start)      state_nx = DEV_ADDR;
        else if (bus_stop)  state_nx = IDLE;
        else if (to_hit)    state_nx = IDLE;
        else if (scl_fall) begin
            case (state)
                DEV_ADDR:   if (byte_done) state_nx = (shift[7:1] == SLAVE_ADDR) ? ACK_ADDR : IDLE;
                ACK_ADDR:   state_nx = shift[0] ? READ_DATA : WORD_ADDR;
                WORD_ADDR:  if (byte_done) state_nx = ACK_WORD;
                ACK_WORD:   state_nx = WRITE_DATA;
                WRITE_DATA: if (byte_done) state_nx = ACK_DATA;
                ACK_DATA:   state_nx = WRITE_DATA;
                READ_DATA:  if (bit_cnt == 4'd7) state_nx = WAIT_MACK;
                WAIT_MACK:  state_nx = mack_nack ? IDLE : READ_DATA;
                default:    state_nx = state;
            endcase
        end
    end

    // datapath: shifting, strobes, pointer and SDA drive
    always_ff @(posedge main_100mhz_clk_i) begin
        if (fpga_rst_i) begin
            sda_oe_o    <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_we_o    <= 1'b0;
            reg_rd_o    <= 1'b0;
            shift       <= '0;
            bit_cnt     <= '0;
            scl_fall_d  <= 1'b0;
            rd_d        <= 1'b0;
            mack_nack   <= 1'b1;
        end else begin
            reg_we_o   <= 1'b0;
            reg_rd_o   <= 1'b0;
            scl_fall_d <= scl_fall;
            rd_d       <= reg_rd_o;
            if (reg_we_o) reg_addr_o <= reg_addr_o + 8'd1;

            if (bus_start || bus_stop || to_hit) begin
                bit_cnt  <= '0;
                sda_oe_o <= 1'b0;
            end else begin
                if (scl_rise) begin
                    case (state)
                        DEV_ADDR, WORD_ADDR, WRITE_DATA:
                            if (!byte_done) begin
                                shift   <= {shift[6:0], filt[1]};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        WAIT_MACK: mack_nack <= filt[1];
                        default: ;
                    endcase
                end
                if (scl_fall) begin
                    case (state)
                        DEV_ADDR:   if (byte_done) bit_cnt <= '0;
                        ACK_ADDR: begin
                            bit_cnt  <= '0;
                            reg_rd_o <= shift[0];
                        end
                        WORD_ADDR: if (byte_done) begin
                            reg_addr_o <= shift;
                            bit_cnt    <= '0;
                        end
                        ACK_WORD:   bit_cnt <= '0;
                        WRITE_DATA: if (byte_done) bit_cnt <= '0;
                        ACK_DATA: begin
                            reg_wdata_o <= shift;
                            reg_we_o    <= 1'b1;
                            bit_cnt     <= '0;
                        end
                        READ_DATA: begin
                            shift   <= {shift[6:0], 1'b1};
                            bit_cnt <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
                        end
                        WAIT_MACK: if (!mack_nack) begin
                            reg_addr_o <= reg_addr_o + 8'd1;
                            reg_rd_o   <= 1'b1;
                            bit_cnt    <= '0;
                        end
                        default: ;
                    endcase
                end
                // the fetched byte arrives late, so its MSB is driven on load
                // rather than on the delayed fall (ACK is held one extra cycle)
                if (rd_d && (state == READ_DATA)) begin
                    shift    <= reg_rdata_i;
                    sda_oe_o <= ~reg_rdata_i[7];
                end else if (scl_fall_d && !reg_rd_o) begin
                    case (state)
                        ACK_ADDR, ACK_WORD, ACK_DATA: sda_oe_o <= 1'b1;
                        READ_DATA:                    sda_oe_o <= ~shift[7];
                        default:                      sda_oe_o <= 1'b0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged I2C master, a register
// model answering read fetches, and strobe monitors.
// Define I2C_SLV_TIMEOUT_EN to also exercise the SCL-low timeout.
module tb_i2c_slave_regfile;

    localparam int Q = 20;   // quarter SCL period in clock cycles
`ifdef I2C_SLV_TIMEOUT_EN
    localparam int TB_TO = 1000;
`else
    localparam int TB_TO = 2_500_000;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe;
    logic [7:0] reg_addr, reg_wdata, rdata;
    logic       reg_we, reg_rd, busy, timeout;
    logic       sda_line;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [256];
    logic [7:0] we_addr_log [64];
    logic [7:0] we_data_log [64];
    int we_cnt = 0, rd_cnt = 0, oe_cnt = 0, busy_cnt = 0, to_cnt = 0;

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .FILTER_LEN(4), .TIMEOUT_CYC(TB_TO)) dut (
        .main_100mhz_clk_i (clk),
        .fpga_rst_i        (rst),
        .scl_i             (scl_m),
        .sda_i             (sda_line),
        .sda_oe_o          (sda_oe),
        .reg_addr_o        (reg_addr),
        .reg_wdata_o       (reg_wdata),
        .reg_we_o          (reg_we),
        .reg_rd_o          (reg_rd),
        .reg_rdata_i       (rdata),
        .busy_o            (busy),
        .timeout_o         (timeout)
    );

    // register model: data presented the cycle after the fetch strobe
    always @(posedge clk) begin
        if (reg_rd) rdata <= mem[reg_addr];
    end

    // strobe and activity monitors
    always @(posedge clk) begin
        if (reg_we) begin
            we_addr_log[we_cnt % 64] <= reg_addr;
            we_data_log[we_cnt % 64] <= reg_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (reg_rd)  rd_cnt   <= rd_cnt + 1;
        if (sda_oe)  oe_cnt   <= oe_cnt + 1;
        if (busy)    busy_cnt <= busy_cnt + 1;
        if (timeout) to_cnt   <= to_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        sda_m = b;
        wait_cyc(Q);
        scl_m = 1'b1;
        wait_cyc(Q);
        r = sda_line;
        wait_cyc(Q);
        scl_m = 1'b0;
        wait_cyc(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
        bit_xfer(1'b1, r);
        ack = ~r;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bit_xfer(~mack, r);
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        wait_cyc(Q);
        scl_m = 1'b1;
        wait_cyc(Q);
        sda_m = 1'b0;
        wait_cyc(Q);
        scl_m = 1'b0;
        wait_cyc(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        wait_cyc(Q);
        scl_m = 1'b1;
        wait_cyc(Q);
        sda_m = 1'b1;
        wait_cyc(2 * Q);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic       r;
        logic [7:0] d;
        int         we0, rd0, oe0, busy0, to0;

        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        mem[8'h20] = 8'h3C;
        mem[8'h21] = 8'h7E;
        mem[8'h41] = 8'h00;
        mem[8'h00] = 8'h00;
        rdata = 8'h00;

        wait_cyc(5);
        rst = 1'b0;
        wait_cyc(2);
        check("rst_sda_oe",  32'(sda_oe),    32'h0);
        check("rst_addr",    32'(reg_addr),  32'h0);
        check("rst_wdata",   32'(reg_wdata), 32'h0);
        check("rst_we",      32'(reg_we),    32'h0);
        check("rst_rd",      32'(reg_rd),    32'h0);
        check("rst_busy",    32'(busy),      32'h0);
        check("rst_timeout", 32'(timeout),   32'h0);
        wait_cyc(10);

        // write: 0xA0, 0x10, 0x5A, 0xC3
        we0 = we_cnt;
        bus_start();
        send_byte(8'hA0, ack); check("wr_ack_dev", 32'(ack), 32'h1);
        send_byte(8'h10, ack); check("wr_ack_word", 32'(ack), 32'h1);
        check("wr_busy", 32'(busy), 32'h1);
        send_byte(8'h5A, ack); check("wr_ack_d0", 32'(ack), 32'h1);
        send_byte(8'hC3, ack); check("wr_ack_d1", 32'(ack), 32'h1);
        bus_stop();
        check("wr_we_count", 32'(we_cnt - we0),   32'd2);
        check("wr_we0_addr", 32'(we_addr_log[we0]),     32'h10);
        check("wr_we0_data", 32'(we_data_log[we0]),     32'h5A);
        check("wr_we1_addr", 32'(we_addr_log[we0 + 1]), 32'h11);
        check("wr_we1_data", 32'(we_data_log[we0 + 1]), 32'hC3);
        check("wr_ptr_after", 32'(reg_addr), 32'h12);
        check("wr_idle_busy", 32'(busy), 32'h0);

        // random read from 0x20: ACK first byte, NACK second
        rd0 = rd_cnt;
        bus_start();
        send_byte(8'hA0, ack); check("rd_ack_dev_w", 32'(ack), 32'h1);
        send_byte(8'h20, ack); check("rd_ack_ptr", 32'(ack), 32'h1);
        bus_start();
        send_byte(8'hA1, ack); check("rd_ack_dev_r", 32'(ack), 32'h1);
        recv_byte(1'b1, d);    check("rd_byte0", 32'(d), 32'h3C);
        recv_byte(1'b0, d);    check("rd_byte1", 32'(d), 32'h7E);
        check("rd_released", 32'(sda_oe), 32'h0);
        bus_stop();
        check("rd_strobes", 32'(rd_cnt - rd0), 32'd2);
        check("rd_ptr_after", 32'(reg_addr), 32'h21);

        // pointer wrap on write
        we0 = we_cnt;
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'hFF, ack);
        send_byte(8'h11, ack); check("wrap_ack0", 32'(ack), 32'h1);
        send_byte(8'h22, ack); check("wrap_ack1", 32'(ack), 32'h1);
        bus_stop();
        check("wrap_we_count", 32'(we_cnt - we0), 32'd2);
        check("wrap_we0_addr", 32'(we_addr_log[we0]),     32'hFF);
        check("wrap_we1_addr", 32'(we_addr_log[we0 + 1]), 32'h00);
        check("wrap_we1_data", 32'(we_data_log[we0 + 1]), 32'h22);
        check("wrap_ptr_after", 32'(reg_addr), 32'h01);

        // address mismatch: never drive, never strobe, never busy
        we0 = we_cnt; rd0 = rd_cnt; oe0 = oe_cnt; busy0 = busy_cnt;
        bus_start();
        send_byte(8'hA2, ack); check("miss_nack_dev", 32'(ack), 32'h0);
        send_byte(8'h55, ack); check("miss_nack_data", 32'(ack), 32'h0);
        bus_stop();
        check("miss_oe_cycles",   32'(oe_cnt - oe0),     32'd0);
        check("miss_we",          32'(we_cnt - we0),     32'd0);
        check("miss_rd",          32'(rd_cnt - rd0),     32'd0);
        check("miss_busy_cycles", 32'(busy_cnt - busy0), 32'd0);

        // SCL glitch, then a STOP four bits into a byte
        we0 = we_cnt;
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h40, ack);
        scl_m = 1'b1;
        wait_cyc(2);
        scl_m = 1'b0;
        wait_cyc(Q);
        send_byte(8'h99, ack); check("glitch_ack", 32'(ack), 32'h1);
        bit_xfer(1'b1, r);
        bit_xfer(1'b0, r);
        bit_xfer(1'b1, r);
        bit_xfer(1'b0, r);
        bus_stop();
        check("glitch_we_count", 32'(we_cnt - we0), 32'd1);
        check("glitch_we_addr",  32'(we_addr_log[we0]), 32'h40);
        check("glitch_we_data",  32'(we_data_log[we0]), 32'h99);
        check("abort_ptr",       32'(reg_addr), 32'h41);

        // reset while driving a read byte whose MSB is 0
        bus_start();
        send_byte(8'hA1, ack); check("rst_rd_ack", 32'(ack), 32'h1);
        check("rst_rd_driving", 32'(sda_oe), 32'h1);
        rst = 1'b1;
        wait_cyc(1);
        check("rst_rd_release", 32'(sda_oe), 32'h0);
        check("rst_rd_busy",    32'(busy),   32'h0);
        rst = 1'b0;
        wait_cyc(2);
        bus_stop();
        check("rst_rd_ptr", 32'(reg_addr), 32'h00);

`ifdef I2C_SLV_TIMEOUT_EN
        // SCL held low mid-read
        to0 = to_cnt;
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h00, ack);
        bus_start();
        send_byte(8'hA1, ack);
        check("to_driving", 32'(sda_oe), 32'h1);
        wait_cyc(TB_TO + 100);
        check("to_pulses",  32'(to_cnt - to0), 32'd1);
        check("to_release", 32'(sda_oe), 32'h0);
        check("to_busy",    32'(busy),   32'h0);
        check("to_ptr",     32'(reg_addr), 32'h00);
        bus_start();
        send_byte(8'hA0, ack); check("to_reack", 32'(ack), 32'h1);
        bus_stop();
`else
        to0 = 0;
        check("no_timeout_pulses", 32'(to_cnt - to0), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
